// File: rtl/sdes_pkg.sv
// sdes_pkg: shared types, S-DES tables and permutation helpers for sdes_controller.
package sdes_pkg;

    localparam int unsigned KEY_W  = 10;
    localparam int unsigned BLK_W  = 8;
    localparam int unsigned WAIT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEYGEN,
        ST_ROUND1,
        ST_ROUND2,
        ST_DONE
    } state_t;

    // Permutation tables: entry i names the source position (1 = MSB) of output position i+1.
    localparam int unsigned P10_TBL [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
    localparam int unsigned P8_TBL  [8]  = '{6, 3, 7, 4, 8, 5, 10, 9};
    localparam int unsigned P4_TBL  [4]  = '{2, 4, 3, 1};
    localparam int unsigned IP_TBL  [8]  = '{2, 6, 3, 1, 4, 8, 5, 7};
    localparam int unsigned IPI_TBL [8]  = '{4, 1, 3, 5, 7, 2, 8, 6};
    localparam int unsigned EP_TBL  [8]  = '{4, 1, 2, 3, 2, 3, 4, 1};

    // S-boxes, row-major, indexed by {row, col}.
    localparam logic [1:0] S0_TBL [16] = '{2'd1, 2'd0, 2'd3, 2'd2,  2'd3, 2'd2, 2'd1, 2'd0,
                                           2'd0, 2'd2, 2'd1, 2'd3,  2'd3, 2'd1, 2'd3, 2'd2};
    localparam logic [1:0] S1_TBL [16] = '{2'd0, 2'd1, 2'd2, 2'd3,  2'd2, 2'd0, 2'd1, 2'd3,
                                           2'd3, 2'd0, 2'd1, 2'd0,  2'd2, 2'd1, 2'd0, 2'd3};

    function automatic logic [9:0] p10(input logic [9:0] x);
        logic [9:0] r;
        r = '0;
        for (int i = 0; i < 10; i++) r[4'(9 - i)] = x[4'(10 - P10_TBL[4'(i)])];
        return r;
    endfunction

    function automatic logic [7:0] p8(input logic [9:0] x);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[3'(7 - i)] = x[4'(10 - P8_TBL[3'(i)])];
        return r;
    endfunction

    function automatic logic [3:0] p4(input logic [3:0] x);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[2'(3 - i)] = x[2'(4 - P4_TBL[2'(i)])];
        return r;
    endfunction

    function automatic logic [7:0] ip(input logic [7:0] x);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[3'(7 - i)] = x[3'(8 - IP_TBL[3'(i)])];
        return r;
    endfunction

    function automatic logic [7:0] ip_inv(input logic [7:0] x);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[3'(7 - i)] = x[3'(8 - IPI_TBL[3'(i)])];
        return r;
    endfunction

    function automatic logic [7:0] ep(input logic [3:0] x);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[3'(7 - i)] = x[2'(4 - EP_TBL[3'(i)])];
        return r;
    endfunction

    // Row is outer bits (1,4), column is inner bits (2,3).
    function automatic logic [1:0] s0_lookup(input logic [3:0] x);
        return S0_TBL[{x[3], x[0], x[2], x[1]}];
    endfunction

    function automatic logic [1:0] s1_lookup(input logic [3:0] x);
        return S1_TBL[{x[3], x[0], x[2], x[1]}];
    endfunction

    function automatic logic [4:0] ls1(input logic [4:0] x);
        return {x[3:0], x[4]};
    endfunction

    function automatic logic [4:0] ls2(input logic [4:0] x);
        return {x[2:0], x[4:3]};
    endfunction

    function automatic logic [7:0] sw(input logic [7:0] x);
        return {x[3:0], x[7:4]};
    endfunction

endpackage

// File: rtl/sdes_if.sv
// sdes_if: request/result handshake bundle of sdes_controller.
interface sdes_if;
    import sdes_pkg::*;

    logic             i_valid;
    logic             o_ready;
    logic             i_mode;
    logic [KEY_W-1:0] i_key;
    logic [BLK_W-1:0] i_data;
    logic             o_valid;
    logic             i_ready;
    logic [BLK_W-1:0] o_data;
    logic             o_busy;

    modport slave (
        input  i_valid, i_mode, i_key, i_data, i_ready,
        output o_ready, o_valid, o_data, o_busy
    );

    modport master (
        output i_valid, i_mode, i_key, i_data, i_ready,
        input  o_ready, o_valid, o_data, o_busy
    );

endinterface

// File: rtl/sdes_fk.sv
// sdes_fk: combinational S-DES round function fk(L,R) = (L ^ F(R,K), R).
module sdes_fk
    import sdes_pkg::*;
(
    input  logic [BLK_W-1:0] i_data,
    input  logic [BLK_W-1:0] i_subkey,
    output logic [BLK_W-1:0] o_result_c
);

    logic [7:0] w_ep;
    logic [3:0] w_f;

    assign w_ep       = ep(i_data[3:0]) ^ i_subkey;
    assign w_f        = p4({s0_lookup(w_ep[7:4]), s1_lookup(w_ep[3:0])});
    assign o_result_c = {i_data[7:4] ^ w_f, i_data[3:0]};

endmodule

// File: rtl/sdes_controller.sv
// sdes_controller: sequences key schedule, IP, fk(Ka), SW, fk(Kb), IP^-1 over one shared fk.
// Optional feature: define SDES_KEY_CACHE_EN to skip KEYGEN when the key repeats.
module sdes_controller
    import sdes_pkg::*;
#(
    parameter int unsigned ROUND_WAIT = 0
) (
    input  logic  i_clk,
    input  logic  i_rst,
    sdes_if.slave bus
);

    state_t            r_state, w_state_nxt;
    logic              r_ready, w_ready_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_busy,  w_busy_nxt;
    logic [WAIT_W-1:0] r_wait,  w_wait_nxt;

    logic [BLK_W-1:0]  r_data, r_mid, r_result, r_k1, r_k2;
    logic [KEY_W-1:0]  r_key;
    logic              r_mode;

    logic              w_accept, w_ld_keys, w_ld_mid, w_ld_res, w_cache_hit;
    logic [KEY_W-1:0]  w_p10, w_ls1, w_ls2;
    logic [BLK_W-1:0]  w_k1, w_k2, w_ka, w_kb, w_fk_data, w_fk_key, w_fk_out;
    logic              w_in_r2;

`ifdef SDES_KEY_CACHE_EN
    logic [KEY_W-1:0]  r_key_cache;
    logic              r_cache_vld;

    assign w_cache_hit = r_cache_vld && (bus.i_key == r_key_cache);

    // Remember the key whose subkeys currently sit in r_k1/r_k2.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_key_cache <= '0;
            r_cache_vld <= 1'b0;
        end else if (w_ld_keys) begin
            r_key_cache <= r_key;
            r_cache_vld <= 1'b1;
        end
    end
`else
    assign w_cache_hit = 1'b0;
`endif

    // Inline key schedule.
    assign w_p10 = p10(r_key);
    assign w_ls1 = {ls1(w_p10[9:5]), ls1(w_p10[4:0])};
    assign w_ls2 = {ls2(w_ls1[9:5]), ls2(w_ls1[4:0])};
    assign w_k1  = p8(w_ls1);
    assign w_k2  = p8(w_ls2);

    // Round input muxes for the shared fk.
    assign w_ka      = r_mode ? r_k2 : r_k1;
    assign w_kb      = r_mode ? r_k1 : r_k2;
    assign w_in_r2   = (r_state == ST_ROUND2);
    assign w_fk_data = w_in_r2 ? r_mid : ip(r_data);
    assign w_fk_key  = w_in_r2 ? w_kb  : w_ka;

    sdes_fk u_fk (
        .i_data     (w_fk_data),
        .i_subkey   (w_fk_key),
        .o_result_c (w_fk_out)
    );

    // State register and registered handshake outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= w_ready_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    // Next-state, wait counter and datapath load strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        w_accept    = 1'b0;
        w_ld_keys   = 1'b0;
        w_ld_mid    = 1'b0;
        w_ld_res    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_valid) begin
                    w_accept = 1'b1;
                    if (w_cache_hit) begin
                        w_state_nxt = ST_ROUND1;
                        w_wait_nxt  = WAIT_W'(ROUND_WAIT);
                    end else begin
                        w_state_nxt = ST_KEYGEN;
                    end
                end
            end
            ST_KEYGEN: begin
                w_ld_keys   = 1'b1;
                w_state_nxt = ST_ROUND1;
                w_wait_nxt  = WAIT_W'(ROUND_WAIT);
            end
            ST_ROUND1: begin
                w_ld_mid = 1'b1;
                if (r_wait == '0) begin
                    w_state_nxt = ST_ROUND2;
                    w_wait_nxt  = WAIT_W'(ROUND_WAIT);
                end else begin
                    w_wait_nxt  = r_wait - WAIT_W'(1);
                end
            end
            ST_ROUND2: begin
                w_ld_res = 1'b1;
                if (r_wait == '0) w_state_nxt = ST_DONE;
                else              w_wait_nxt  = r_wait - WAIT_W'(1);
            end
            ST_DONE: begin
                if (bus.i_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_ready_nxt = (w_state_nxt == ST_IDLE);
        w_valid_nxt = (w_state_nxt == ST_DONE);
        w_busy_nxt  = (w_state_nxt != ST_IDLE);
    end

    // Request capture, subkeys and round results.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data   <= '0;
            r_key    <= '0;
            r_mode   <= 1'b0;
            r_k1     <= '0;
            r_k2     <= '0;
            r_mid    <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_data <= bus.i_data;
                r_key  <= bus.i_key;
                r_mode <= bus.i_mode;
            end
            if (w_ld_keys) begin
                r_k1 <= w_k1;
                r_k2 <= w_k2;
            end
            if (w_ld_mid) r_mid    <= sw(w_fk_out);
            if (w_ld_res) r_result <= ip_inv(w_fk_out);
        end
    end

    assign bus.o_ready = r_ready;
    assign bus.o_valid = r_valid;
    assign bus.o_busy  = r_busy;
    assign bus.o_data  = r_result;

endmodule

// File: tb/tb_sdes_controller.sv
// tb_sdes_controller: scoreboard bench for sdes_controller (ROUND_WAIT = 0 and 3 instances).
module tb_sdes_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sdes_if if0 ();
    sdes_if if3 ();

    sdes_controller #(.ROUND_WAIT(0)) dut0 (.i_clk(clk), .i_rst(rst), .bus(if0));
    sdes_controller #(.ROUND_WAIT(3)) dut3 (.i_clk(clk), .i_rst(rst), .bus(if3));

    typedef struct {
        logic [7:0] data;
        int         lat;
    } exp_t;

    exp_t       exp_q [$];
    int         n_total = 0;
    int         n_bad   = 0;
    logic       cache_vld [2];
    logic [9:0] cache_key [2];

    localparam logic [1:0] S0_M [4][4] = '{'{2'd1, 2'd0, 2'd3, 2'd2}, '{2'd3, 2'd2, 2'd1, 2'd0},
                                          '{2'd0, 2'd2, 2'd1, 2'd3}, '{2'd3, 2'd1, 2'd3, 2'd2}};
    localparam logic [1:0] S1_M [4][4] = '{'{2'd0, 2'd1, 2'd2, 2'd3}, '{2'd2, 2'd0, 2'd1, 2'd3},
                                          '{2'd3, 2'd0, 2'd1, 2'd0}, '{2'd2, 2'd1, 2'd0, 2'd3}};

    // Reference S-DES model.
    function automatic logic [7:0] m_ip(input logic [7:0] x);
        return {x[6], x[2], x[5], x[7], x[4], x[0], x[3], x[1]};
    endfunction
    function automatic logic [7:0] m_ipinv(input logic [7:0] x);
        return {x[4], x[7], x[5], x[3], x[1], x[6], x[0], x[2]};
    endfunction
    function automatic logic [9:0] m_p10(input logic [9:0] k);
        return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
    endfunction
    function automatic logic [7:0] m_p8(input logic [9:0] k);
        return {k[4], k[7], k[3], k[6], k[2], k[5], k[0], k[1]};
    endfunction
    function automatic logic [7:0] m_fk(input logic [7:0] d, input logic [7:0] k);
        logic [7:0] e;
        logic [3:0] s;
        logic [3:0] f;
        e = {d[0], d[3], d[2], d[1], d[2], d[1], d[0], d[3]} ^ k;
        s = {S0_M[{e[7], e[4]}][{e[6], e[5]}], S1_M[{e[3], e[0]}][{e[2], e[1]}]};
        f = {s[2], s[0], s[1], s[3]};
        return {d[7:4] ^ f, d[3:0]};
    endfunction
    function automatic logic [7:0] m_sdes(input logic mode, input logic [9:0] key, input logic [7:0] data);
        logic [9:0] p, l1, l2;
        logic [7:0] k1, k2, t;
        p  = m_p10(key);
        l1 = {p[8:5], p[9], p[3:0], p[4]};
        l2 = {l1[7:5], l1[9:8], l1[2:0], l1[4:3]};
        k1 = m_p8(l1);
        k2 = m_p8(l2);
        t  = m_fk(m_ip(data), mode ? k2 : k1);
        t  = {t[3:0], t[7:4]};
        t  = m_fk(t, mode ? k1 : k2);
        return m_ipinv(t);
    endfunction

    function automatic logic is_hit(input int sel, input logic [9:0] key);
`ifdef SDES_KEY_CACHE_EN
        return cache_vld[sel] && (cache_key[sel] == key);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [10:0] mon(input int sel);
        if (sel == 0) return {if0.o_valid, if0.o_ready, if0.o_busy, if0.o_data};
        return {if3.o_valid, if3.o_ready, if3.o_busy, if3.o_data};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic m, input logic [9:0] k, input logic [7:0] d);
        if (sel == 0) begin
            if0.i_valid = v; if0.i_mode = m; if0.i_key = k; if0.i_data = d;
        end else begin
            if3.i_valid = v; if3.i_mode = m; if3.i_key = k; if3.i_data = d;
        end
    endtask

    task automatic set_ready(input int sel, input logic r);
        if (sel == 0) if0.i_ready = r;
        else          if3.i_ready = r;
    endtask

    // One request: push expectation, wait for o_valid, pop and compare, then handshake.
    task automatic do_req(input int sel, input logic mode, input logic [9:0] key, input logic [7:0] data,
                          input logic [7:0] exp_data, input int hold, input logic scramble);
        int          j;
        logic [10:0] m;
        exp_t        e;
        j = 0;
        m = mon(sel);
        while (!m[9] && j < 20) begin
            @(negedge clk);
            j++;
            m = mon(sel);
        end
        chk("ready_before_req", 32'(m[9]), 32'd1);
        e.data = exp_data;
        e.lat  = (is_hit(sel, key) ? 2 : 3) + ((sel == 0) ? 0 : 6);
        exp_q.push_back(e);
        cache_vld[sel] = 1'b1;
        cache_key[sel] = key;
        set_ready(sel, hold == 0);
        drive(sel, 1'b1, mode, key, data);
        @(negedge clk);
        m = mon(sel);
        chk("ready_low_after_accept", 32'(m[9]), 32'd0);
        chk("busy_after_accept", 32'(m[8]), 32'd1);
        drive(sel, 1'b0, mode, key, data);
        j = 0;
        while (!m[10] && j < 40) begin
            if (scramble) drive(sel, 1'b1, 1'($urandom), 10'($urandom), 8'($urandom));
            @(negedge clk);
            j++;
            m = mon(sel);
        end
        drive(sel, 1'b0, 1'b0, 10'd0, 8'd0);
        e = exp_q.pop_front();
        chk("latency", 32'(j), 32'(e.lat));
        chk("result", 32'(m[7:0]), 32'(e.data));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            m = mon(sel);
            chk("bp_valid", 32'(m[10]), 32'd1);
            chk("bp_data", 32'(m[7:0]), 32'(e.data));
            chk("bp_ready", 32'(m[9]), 32'd0);
        end
        set_ready(sel, 1'b1);
        @(negedge clk);
        m = mon(sel);
        chk("valid_one_cycle", 32'(m[10]), 32'd0);
        chk("ready_after_hs", 32'(m[9]), 32'd1);
    endtask

    // Reset in ROUND1 aborts the request; outputs must clear immediately.
    task automatic abort_req(input logic [9:0] key, input logic [7:0] data);
        logic [10:0] m;
        logic        hit;
        hit = is_hit(0, key);
        drive(0, 1'b1, 1'b0, key, data);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, key, data);
        if (!hit) @(negedge clk);
        m = mon(0);
        chk("busy_in_round1", 32'(m[8]), 32'd1);
        rst = 1'b1;
        #1;
        m = mon(0);
        chk("abort_outputs_zero", 32'(m), 32'd0);
        cache_vld[0] = 1'b0;
        cache_vld[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        m = mon(0);
        chk("ready_after_abort", 32'(m[9]), 32'd1);
        chk("valid_after_abort", 32'(m[10]), 32'd0);
    endtask

    initial begin
        logic [10:0] m;
        logic [9:0]  k, ka, kb;
        logic [7:0]  d;
        logic        md;
        cache_vld[0] = 1'b0;
        cache_vld[1] = 1'b0;
        cache_key[0] = '0;
        cache_key[1] = '0;
        drive(0, 1'b0, 1'b0, 10'd0, 8'd0);
        drive(1, 1'b0, 1'b0, 10'd0, 8'd0);
        set_ready(0, 1'b1);
        set_ready(1, 1'b1);

        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs0", 32'(mon(0)), 32'd0);
        chk("reset_outputs3", 32'(mon(1)), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        m = mon(0);
        chk("ready_after_reset0", 32'(m[9]), 32'd1);
        m = mon(1);
        chk("ready_after_reset3", 32'(m[9]), 32'd1);

        k = 10'b1010000010;
        do_req(0, 1'b0, k, 8'b10010111, 8'b00111000, 0, 1'b0);
        do_req(0, 1'b1, k, 8'b00111000, 8'b10010111, 0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) k = 10'($urandom);
            md = 1'($urandom);
            d  = 8'($urandom);
            do_req(0, md, k, d, m_sdes(md, k, d), 0, 1'b0);
        end

        k = 10'h2d3;
        d = 8'h5a;
        do_req(0, 1'b0, k, d, m_sdes(1'b0, k, d), 10, 1'b0);

        abort_req(10'h155, 8'ha5);
        do_req(0, 1'b0, 10'h155, 8'ha5, m_sdes(1'b0, 10'h155, 8'ha5), 0, 1'b0);

        k = 10'b1010000010;
        do_req(1, 1'b0, k, 8'b10010111, 8'b00111000, 0, 1'b1);
        do_req(1, 1'b1, k, 8'b00111000, 8'b10010111, 0, 1'b1);

        ka = 10'h0f1;
        kb = 10'h30e;
        do_req(0, 1'b0, ka, 8'h3c, m_sdes(1'b0, ka, 8'h3c), 0, 1'b0);
        do_req(0, 1'b1, ka, 8'hc4, m_sdes(1'b1, ka, 8'hc4), 0, 1'b0);
        do_req(0, 1'b0, kb, 8'h81, m_sdes(1'b0, kb, 8'h81), 0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/sdes_controller.md
# sdes_controller

Sequencing controller for the S-DES datapath. Accepts one 8-bit block, a 10-bit key and a direction, then steps the shared permutation and round-function logic through the full cipher:

- key schedule
- IP
- fk with the first subkey
- SW
- fk with the second subkey
- IP⁻¹

It returns the result over a valid/ready handshake. It sits between the board-level I/O (switch/UART front end) and the combinational S-DES permutation and S-box blocks.

## Interface
- ROUND_WAIT, default 0: extra wait cycles after each round state, range 0–15, used to pace the shared fk logic.

- i_clk  input  1  system clock, rising edge
- i_rst  input  1  asynchronous, active-high reset
- i_valid  input  1  request valid
- o_ready  output  1  controller can accept a request
- i_mode  input  1  0 = encrypt, 1 = decrypt
- i_key  input  10  cipher key
- i_data  input  8  plaintext or ciphertext block
- o_valid  output  1  result valid
- i_ready  input  1  consumer accepts result
- o_data  output  8  result block
- o_busy  output  1  request in flight (state ≠ IDLE)

## Operation
- FSM states, all in package enum:
  - IDLE: o_ready = 1. On i_valid, register i_data, i_key and i_mode, then go to KEYGEN.
  - KEYGEN: compute and register the subkeys.
    - K1 = P8(LS1(P10(key))).
    - K2 = P8(LS2(LS1(P10(key)))).
    - Then go to ROUND1.
  - ROUND1: state register ← SW(fk(IP(data), Ka)). Go to ROUND2 after ROUND_WAIT wait cycles.
  - ROUND2: result register ← IP⁻¹(fk(state, Kb)). Go to DONE after ROUND_WAIT wait cycles.
  - DONE: o_valid = 1. On i_ready, go to IDLE.
- Subkey order:
  - Encrypt: Ka = K1, Kb = K2.
  - Decrypt: Ka = K2, Kb = K1.
- fk(L,R) = (L ⊕ F(R,K), R), where F = P4(S0‖S1(EP(R) ⊕ K)).
- Bit conventions:
  - Bit 7 (bit 9 for the key) is permutation position 1.
  - EP table: 4 1 2 3 2 3 4 1.
- Inputs are ignored outside IDLE.
- o_data is stable from DONE entry until the handshake completes.
- Wait counter:
  - 4-bit.
  - Reloads to ROUND_WAIT on entry to ROUND1 and ROUND2.
  - Advances the state when it reaches 0.
- Reset values: o_ready = 0 during reset; all other outputs 0.
  - IDLE is entered on deassertion, so o_ready = 1 in the first cycle after reset.
  - Reset mid-operation aborts the request with no output.
  - Subkeys, the wait counter and the key cache are cleared.

## Timing
- Latency: a request accepted at edge N gives o_valid high from edge N+3+2·ROUND_WAIT.
- o_ready falls at edge N and returns the cycle after the output handshake edge.
- There is no overlap of accept and output.
- With i_ready held high, o_valid lasts exactly 1 cycle.
- With i_ready low, DONE holds indefinitely.
- Throughput with ROUND_WAIT = 0 and i_ready = 1: one block per 5 cycles.

## Configuration
- SDES_KEY_CACHE_EN defined:
  - The controller keeps the last key and a cache-valid bit, which is cleared on reset.
  - If the accepted key equals the cached key and the cache is valid, KEYGEN is skipped: IDLE goes directly to ROUND1.
  - Latency drops to 2+2·ROUND_WAIT.
- SDES_KEY_CACHE_EN undefined: KEYGEN always runs and no cache registers exist.

## Structure
- sdes_pkg holds:
  - the state enum;
  - the S0/S1 lookup constants;
  - the P10, P8, P4, IP, IP⁻¹ and EP index constants;
  - permutation functions.
- One sub-module, sdes_fk: combinational round function with ports data (8), subkey (8) and result (8). It is instantiated once and shared between ROUND1 and ROUND2 through input muxes.
- The key schedule is inline (combinational into the KEYGEN registers).

## Test plan
- Encrypt, ROUND_WAIT = 0: key 1010000010, data 10010111 → o_data 00111000 at edge N+3. Internal K1 = 10100100, K2 = 01000011.
- Decrypt with the same key, data 00111000 → o_data 10010111.
- Backpressure: hold i_ready low for 10 cycles after o_valid. o_valid and o_data stay stable and o_ready stays 0; completion occurs on the first edge with i_ready = 1.
- Reset asserted during ROUND1: all outputs 0 immediately, o_ready = 1 the cycle after release. A new request completes correctly.
- ROUND_WAIT = 3: latency is 9 cycles. Inputs changed mid-operation have no effect on the result.
- With SDES_KEY_CACHE_EN:
  - Two back-to-back requests with the same key: the second has latency 2.
  - A third request with a different key: latency 3.
  - All results match the reference values.
